// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN parameter loader: state encoding and
// chain-length arithmetic used to size the serial parameter stream.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int chain_len(input int neurons, input int inputs, input int bias_bits);
    return neurons * (inputs + bias_bits);
  endfunction

  function automatic int nbytes(input int len);
    return (len + 7) / 8;
  endfunction

endpackage

// File: rtl/bnn_param_serializer.sv
// Byte register with bit-in-byte counter; presents the MSB on param_out
// while the chain is being shifted.
module bnn_param_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       param_out,
  output logic       last_bit
);

  logic [7:0] byte_r;
  logic [2:0] bit_cnt_r;

  // Capture a fresh byte or shift the current one MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_r    <= 8'd0;
      bit_cnt_r <= 3'd0;
    end else if (load) begin
      byte_r    <= data;
      bit_cnt_r <= 3'd0;
    end else if (shift) begin
      byte_r    <= {byte_r[6:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else begin
      byte_r    <= byte_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Gated so the chain input is quiet whenever setup is low.
  assign param_out = enable & byte_r[7];
  assign last_bit  = (bit_cnt_r == 3'd7);

endmodule

// File: rtl/bnn_param_loader.sv
// Streams a full neuron-chain parameter set from a byte interface into the
// serial setup/param_in chain; reports busy, a done pulse and a loaded level.
module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int NEURONS   = 4,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_out,
  output logic       busy,
  output logic       done,
  output logic       loaded
);

  localparam int CHAIN_LEN = chain_len(NEURONS, INPUTS, BIAS_BITS);
  localparam int CW        = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] REM_INIT = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] REM_ONE  = CW'(1);
  localparam logic [CW-1:0] REM_ZERO = CW'(0);

  state_t        state_r, state_nx;
  logic [CW-1:0] rem_r, rem_nx;
  logic          loaded_r, loaded_nx;
  logic          in_ready_r, setup_r, busy_r, done_r;
  logic          load_s, shift_s, last_bit_s;

  // Next-state, remaining-bit count and serializer control.
  always_comb begin
    state_nx  = state_r;
    rem_nx    = rem_r;
    loaded_nx = loaded_r;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx  = ST_FETCH;
          rem_nx    = REM_INIT;
          loaded_nx = 1'b0;
        end else begin
          state_nx  = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (in_valid && in_ready_r) begin
          load_s   = 1'b1;
          state_nx = ST_SHIFT;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (rem_r != REM_ZERO) begin
          rem_nx = rem_r - REM_ONE;
        end else begin
          rem_nx = REM_ZERO;
        end
        // The final partial byte ends here, dropping its unused low bits.
        if (rem_r <= REM_ONE) begin
          state_nx  = ST_DONE;
          loaded_nx = 1'b1;
        end else if (last_bit_s) begin
          state_nx  = ST_FETCH;
        end else begin
          state_nx  = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx  = ST_IDLE;
        loaded_nx = 1'b0;
      end
    endcase
  end

  // State, counter and decoded outputs, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rem_r      <= REM_ZERO;
      loaded_r   <= 1'b0;
      in_ready_r <= 1'b0;
      setup_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      rem_r      <= rem_nx;
      loaded_r   <= loaded_nx;
      in_ready_r <= (state_nx == ST_FETCH);
      setup_r    <= (state_nx == ST_SHIFT);
      busy_r     <= (state_nx != ST_IDLE);
      done_r     <= (state_nx == ST_DONE);
    end
  end

  bnn_param_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .shift     (shift_s),
    .enable    (setup_r),
    .data      (in_data),
    .param_out (param_out),
    .last_bit  (last_bit_s)
  );

  assign in_ready = in_ready_r;
  assign setup    = setup_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign loaded   = loaded_r;

endmodule
